// File: rtl/seven_seg_capture.sv
// seven_seg_capture: reads a multiplexed 4-digit 7-segment bus (select + segments),
// waits for each digit pattern to settle, decodes it back to a 4-bit digit and
// publishes a full 4-digit frame once every digit has been seen.
// Optional feature: define SEG_CAPTURE_HEX_EN to also decode the A..F glyphs.
module seven_seg_capture #(
   parameter logic [3:0]  SETTLE     = 4'd8,
   parameter logic [19:0] TIMEOUT    = 20'd500000,
   parameter logic        ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] select,
   input  logic [7:0] segments,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] c,
   output logic [3:0] d,
   output logic [3:0] dp,
   output logic [3:0] seg_err,
   output logic       frame_valid,
   output logic       stale
);

   // Synchronizer flops reset to the bus idle level so nothing looks lit after reset.
   localparam logic [11:0] IDLE_LVL = {12{ACTIVE_LOW}};

   logic [11:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic [11:0]      bus;          // synced, active-high {select, dp, gfedcba}
   logic [11:0]      prev_q, prev_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             match, one_hot, capture;
   logic [3:0]       dec_digit;
   logic             dec_err;
   logic [3:0][3:0]  hold_dig_q, hold_dig_d;
   logic [3:0]       hold_dp_q, hold_dp_d;
   logic [3:0]       hold_err_q, hold_err_d;
   logic [3:0]       mask_q, mask_d;
   logic             publish;
   logic [3:0][3:0]  out_dig_q, out_dig_d;
   logic [3:0]       out_dp_q, out_dp_d;
   logic [3:0]       out_err_q, out_err_d;
   logic             frame_valid_q, frame_valid_d;
   logic [19:0]      idle_q, idle_d;
   logic             stale_q, stale_d;

   // Input path: two-flop synchronizer, then normalise polarity to active-high.
   always_comb begin
      sync1_d = {select, segments};
      sync2_d = sync1_q;
      bus     = ACTIVE_LOW ? ~sync2_q : sync2_q;
   end

   // Stability tracking: count consecutive identical samples, capture exactly once per
   // stable period when SETTLE identical samples have been seen on a one-hot select.
   always_comb begin
      prev_d  = bus;
      match   = (bus == prev_q);
      one_hot = (bus[11:8] != 4'd0) && ((bus[11:8] & (bus[11:8] - 4'd1)) == 4'd0);
      if (!match)
         cnt_d = 4'd0;
      else if (cnt_q == SETTLE)
         cnt_d = SETTLE;
      else
         cnt_d = cnt_q + 4'd1;
      capture = match && (cnt_q == SETTLE - 4'd2) && one_hot;
   end

   // Glyph decode of the settled pattern; anything unrecognised reads as 0 with error.
   always_comb begin
      dec_digit = 4'd0;
      dec_err   = 1'b0;
      case (bus[6:0])
         7'h3F: dec_digit = 4'd0;
         7'h06: dec_digit = 4'd1;
         7'h5B: dec_digit = 4'd2;
         7'h4F: dec_digit = 4'd3;
         7'h66: dec_digit = 4'd4;
         7'h6D: dec_digit = 4'd5;
         7'h7D: dec_digit = 4'd6;
         7'h07: dec_digit = 4'd7;
         7'h7F: dec_digit = 4'd8;
         7'h6F: dec_digit = 4'd9;
`ifdef SEG_CAPTURE_HEX_EN
         7'h77: dec_digit = 4'hA;
         7'h7C: dec_digit = 4'hB;
         7'h39: dec_digit = 4'hC;
         7'h5E: dec_digit = 4'hD;
         7'h79: dec_digit = 4'hE;
         7'h71: dec_digit = 4'hF;
`endif
         default: dec_err = 1'b1;
      endcase
   end

   // Frame assembly: captures land in holding regs; a full mask publishes on the next
   // edge and restarts the mask, keeping any capture that lands in the publish cycle.
   always_comb begin
      hold_dig_d = hold_dig_q;
      hold_dp_d  = hold_dp_q;
      hold_err_d = hold_err_q;
      publish    = (mask_q == 4'hF);
      mask_d     = publish ? 4'h0 : mask_q;
      for (int i = 0; i < 4; i++) begin
         if (capture && bus[8+i]) begin
            hold_dig_d[i] = dec_digit;
            hold_dp_d[i]  = bus[7];
            hold_err_d[i] = dec_err;
            mask_d[i]     = 1'b1;
         end
      end
      out_dig_d     = publish ? hold_dig_q : out_dig_q;
      out_dp_d      = publish ? hold_dp_q  : out_dp_q;
      out_err_d     = publish ? hold_err_q : out_err_q;
      frame_valid_d = publish;
   end

   // Staleness: idle counter restarts on capture; stale sets on saturation and only a
   // publish clears it (publish wins a same-cycle timeout).
   always_comb begin
      if (capture)
         idle_d = 20'd0;
      else if (idle_q == TIMEOUT)
         idle_d = TIMEOUT;
      else
         idle_d = idle_q + 20'd1;
      if (publish)
         stale_d = 1'b0;
      else if (idle_d == TIMEOUT)
         stale_d = 1'b1;
      else
         stale_d = stale_q;
   end

   // State registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= IDLE_LVL;
         sync2_q       <= IDLE_LVL;
         prev_q        <= '0;
         cnt_q         <= '0;
         hold_dig_q    <= '0;
         hold_dp_q     <= '0;
         hold_err_q    <= '0;
         mask_q        <= '0;
         out_dig_q     <= '0;
         out_dp_q      <= '0;
         out_err_q     <= '0;
         frame_valid_q <= 1'b0;
         idle_q        <= '0;
         stale_q       <= 1'b1;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         hold_dig_q    <= hold_dig_d;
         hold_dp_q     <= hold_dp_d;
         hold_err_q    <= hold_err_d;
         mask_q        <= mask_d;
         out_dig_q     <= out_dig_d;
         out_dp_q      <= out_dp_d;
         out_err_q     <= out_err_d;
         frame_valid_q <= frame_valid_d;
         idle_q        <= idle_d;
         stale_q       <= stale_d;
      end
   end

   assign a           = out_dig_q[0];
   assign b           = out_dig_q[1];
   assign c           = out_dig_q[2];
   assign d           = out_dig_q[3];
   assign dp          = out_dp_q;
   assign seg_err     = out_err_q;
   assign frame_valid = frame_valid_q;
   assign stale       = stale_q;

endmodule
